// File: rtl/bus_uart_tx_pkg.sv
// Shared definitions for the bus-mapped UART transmitter: register offsets,
// STATUS bit positions, transmitter state encoding and the STATUS packer.
package bus_uart_tx_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 5;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] build_status(
        input logic                busy,
        input logic                full,
        input logic                empty,
        input logic                ovf,
        input logic [ST_CNT_W-1:0] cnt
    );
        logic [31:0] s;
        s                             = 32'd0;
        s[ST_BUSY]                    = busy;
        s[ST_FULL]                    = full;
        s[ST_EMPTY]                   = empty;
        s[ST_OVF]                     = ovf;
        s[ST_CNT_LSB +: ST_CNT_W]     = cnt;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting for the serialiser. A push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | i_pop);

    // Storage array; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MEM-stage data bus.
// Define BUS_UART_TX_IRQ_EN to build the transmit-complete interrupt.
module bus_uart_tx
    import bus_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0020,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        Mem_rd,
    input  logic        Mem_wr,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        uart_txd,
    output logic        irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             w_hit;
    logic [1:0]       w_off;
    logic             w_wr_txdata;
    logic             w_wr_status;
    logic             w_wr_baud;
    logic             w_wr_ctrl;
    logic             w_ovf_set;
    logic             w_unused;
    logic             w_irq_en_rd;
    logic [15:0]      r_baud_div;
    logic             r_tx_en;
    logic             r_ovf;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [7:0]       w_fifo_dout;
    logic             w_pop;
    tx_state_e        r_state;
    tx_state_e        w_state_next;
    logic [15:0]      r_baud_cnt;
    logic [15:0]      r_div_lat;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_idx_next;
    logic [7:0]       r_byte;
    logic             r_txd;
    logic             w_txd_next;
    logic             w_bit_done;

    assign w_hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off       = addr[3:2];
    assign w_wr_txdata = Mem_wr & w_hit & (w_off == OFF_TXDATA);
    assign w_wr_status = Mem_wr & w_hit & (w_off == OFF_STATUS);
    assign w_wr_baud   = Mem_wr & w_hit & (w_off == OFF_BAUD);
    assign w_wr_ctrl   = Mem_wr & w_hit & (w_off == OFF_CTRL);
    assign w_unused    = ^{addr[1:0], Write_data[31:16]};

    assign w_pop      = (r_state == IDLE) & r_tx_en & ~w_empty;
    assign w_ovf_set  = w_wr_txdata & w_full & ~w_pop;
    assign w_bit_done = (r_baud_cnt == r_div_lat);
    assign uart_txd   = r_txd;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_wr_txdata),
        .i_pop   (w_pop),
        .i_data  (Write_data[7:0]),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Software-visible registers; a new overflow beats a same-cycle W1C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_baud_div <= DIV_RESET;
            r_tx_en    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_wr_baud) r_baud_div <= Write_data[15:0];
            if (w_wr_ctrl) r_tx_en    <= Write_data[CTRL_TX_EN];
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && Write_data[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef BUS_UART_TX_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    // Interrupt enable and the registered transmit-complete request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_irq_en <= Write_data[CTRL_IRQ_EN];
            r_irq <= r_irq_en & r_tx_en & w_empty & (r_state == IDLE);
        end
    end

    assign w_irq_en_rd = r_irq_en;
    assign irq         = r_irq;
`else
    assign w_irq_en_rd = 1'b0;
    assign irq         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pop) w_state_next = START; else w_state_next = IDLE;
            START:   if (w_bit_done) w_state_next = DATA; else w_state_next = START;
            DATA:    if (w_bit_done && (r_bit_idx == 3'd7)) w_state_next = STOP;
                     else w_state_next = DATA;
            STOP:    if (w_bit_done) w_state_next = IDLE; else w_state_next = STOP;
            default: w_state_next = IDLE;
        endcase
    end

    // Line level for the next cycle, so the serial output can be a flop.
    always_comb begin
        w_idx_next = r_bit_idx;
        w_txd_next = 1'b1;
        if ((r_state == DATA) && w_bit_done) begin
            w_idx_next = r_bit_idx + 3'd1;
        end else begin
            w_idx_next = r_bit_idx;
        end
        case (w_state_next)
            IDLE:    w_txd_next = 1'b1;
            START:   w_txd_next = 1'b0;
            DATA:    w_txd_next = r_byte[w_idx_next];
            STOP:    w_txd_next = 1'b1;
            default: w_txd_next = 1'b1;
        endcase
    end

    // Baud timing, bit index and per-frame latches of byte and divisor.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_txd      <= 1'b1;
            r_byte     <= 8'd0;
            r_div_lat  <= 16'd0;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
        end else begin
            r_txd <= w_txd_next;
            if (w_pop) begin
                r_byte     <= w_fifo_dout;
                r_div_lat  <= r_baud_div;
                r_baud_cnt <= 16'd0;
                r_bit_idx  <= 3'd0;
            end else if (r_state != IDLE) begin
                if (w_bit_done) begin
                    r_baud_cnt <= 16'd0;
                    r_bit_idx  <= w_idx_next;
                end else begin
                    r_baud_cnt <= r_baud_cnt + 16'd1;
                end
            end
        end
    end

    // Combinational load data so it is valid in the same MEM cycle.
    always_comb begin
        Read_data = 32'd0;
        if (Mem_rd && w_hit) begin
            case (w_off)
                OFF_STATUS: Read_data = build_status(r_state != IDLE, w_full, w_empty,
                                                     r_ovf, ST_CNT_W'(w_count));
                OFF_BAUD:   Read_data = {16'd0, r_baud_div};
                OFF_CTRL:   Read_data = {30'd0, w_irq_en_rd, r_tx_en};
                default:    Read_data = 32'd0;
            endcase
        end else begin
            Read_data = 32'd0;
        end
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: directed scenarios plus randomized
// rounds, with frames checked against a byte-queue model of the line.
module tb_bus_uart_tx;
    import bus_uart_tx_pkg::*;

    localparam logic [31:0] BASE  = 32'h4000_0020;
    localparam int          DEPTH = 4;
    localparam int          LIMIT = 200;
`ifdef BUS_UART_TX_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'd0;
    logic        Mem_rd = 1'b0;
    logic        Mem_wr = 1'b0;
    logic [31:0] Write_data = 32'd0;
    logic [31:0] Read_data;
    logic        uart_txd;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    bus_uart_tx dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .Mem_rd     (Mem_rd),
        .Mem_wr     (Mem_wr),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .uart_txd   (uart_txd),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller sits at a falling edge; the write lands on the next rising edge.
    task automatic bus_write(input logic [1:0] off, input logic [31:0] d);
        addr       = BASE + {28'd0, off, 2'b00};
        Write_data = d;
        Mem_wr     = 1'b1;
        @(negedge clk);
        Mem_wr     = 1'b0;
        addr       = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
        addr   = BASE + {28'd0, off, 2'b00};
        Mem_rd = 1'b1;
        #1;
        d      = Read_data;
        Mem_rd = 1'b0;
        addr   = 32'd0;
    endtask

    function automatic logic [31:0] status_exp(input int busy, input int full, input int empty,
                                               input int ovf, input int cnt);
        return 32'(cnt * 16 + ovf * 8 + empty * 4 + full * 2 + busy);
    endfunction

    // Waits for the start bit, then checks every cycle of the 10-bit frame.
    task automatic expect_frame(input logic [7:0] b, input int div, input int exp_gap,
                                input string tag);
        int         waited;
        int         bad;
        logic [7:0] got;
        logic       lvl;
        waited = 0;
        bad    = 0;
        got    = 8'd0;
        while (uart_txd !== 1'b0 && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        check_eq({tag, "_gap"}, 32'(waited), 32'(exp_gap));
        if (waited >= LIMIT) return;
        for (int bit_n = 0; bit_n < 10; bit_n++) begin
            if (bit_n == 0)      lvl = 1'b0;
            else if (bit_n == 9) lvl = 1'b1;
            else                 lvl = b[bit_n-1];
            for (int c = 0; c <= div; c++) begin
                if (uart_txd !== lvl) bad++;
                if (bit_n >= 1 && bit_n <= 8 && c == div / 2) got[bit_n-1] = uart_txd;
                @(negedge clk);
            end
        end
        check_eq({tag, "_levels"}, 32'(bad), 32'd0);
        check_eq({tag, "_byte"}, {24'd0, got}, {24'd0, b});
    endtask

    logic [31:0] rd;
    logic [7:0]  q[$];
    logic [7:0]  bx;
    logic [7:0]  by;
    int          lows;
    int          div;
    int          n;
    logic        ovf;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        bus_read(OFF_STATUS, rd); check_eq("rst_status", rd, 32'h0000_0004);
        bus_read(OFF_BAUD, rd);   check_eq("rst_baud", rd, 32'd433);
        bus_read(OFF_CTRL, rd);   check_eq("rst_ctrl", rd, 32'd0);
        bus_read(OFF_TXDATA, rd); check_eq("txdata_read", rd, 32'd0);
        check_eq("rst_txd", {31'd0, uart_txd}, 32'd1);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        addr = BASE + 32'd16; Mem_rd = 1'b1; #1;
        check_eq("miss_read", Read_data, 32'd0);
        addr = BASE + 32'd8; Mem_rd = 1'b0; #1;
        check_eq("no_rd_read", Read_data, 32'd0);
        @(negedge clk);

        // Single frame, 4-cycle bits.
        bus_write(OFF_BAUD, 32'd3);
        bus_write(OFF_CTRL, 32'd1);
        bus_write(OFF_TXDATA, 32'h0000_00A5);
        expect_frame(8'hA5, 3, 1, "a5");
        bus_read(OFF_STATUS, rd); check_eq("a5_done_status", rd, 32'h0000_0004);

        // Overflow with transmitter disabled, then W1C and drain.
        bus_write(OFF_CTRL, 32'd0);
        q.delete();
        for (int i = 0; i < 5; i++) begin
            bx = 8'($urandom);
            if (q.size() < DEPTH) q.push_back(bx);
            bus_write(OFF_TXDATA, {24'd0, bx});
        end
        bus_read(OFF_STATUS, rd); check_eq("ovf_status", rd, status_exp(0, 1, 0, 1, 4));
        bus_write(OFF_STATUS, 32'h0000_0008);
        bus_read(OFF_STATUS, rd); check_eq("w1c_status", rd, status_exp(0, 1, 0, 0, 4));
        bus_write(OFF_CTRL, 32'd1);
        while (q.size() > 0) expect_frame(q.pop_front(), 3, 1, "drain");

        // Back-to-back frames at 2-cycle bits, interrupt on completion.
        bus_write(OFF_BAUD, 32'd1);
        bus_write(OFF_CTRL, 32'd3);
        bus_read(OFF_CTRL, rd); check_eq("ctrl_read", rd, IRQ_ON ? 32'd3 : 32'd1);
        bus_write(OFF_TXDATA, 32'h0000_0000);
        bus_write(OFF_TXDATA, 32'h0000_00FF);
        expect_frame(8'h00, 1, 0, "b2b0");
        expect_frame(8'hFF, 1, 1, "b2b1");
        check_eq("irq_pre", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check_eq("irq_rise", {31'd0, irq}, {31'd0, IRQ_ON});

        // Divisor changed mid-frame applies to the next frame only.
        bus_write(OFF_BAUD, 32'd3);
        bx = 8'($urandom);
        by = 8'($urandom);
        bus_write(OFF_TXDATA, {24'd0, bx});
        fork
            expect_frame(bx, 3, 1, "mid_old");
            begin
                check_eq("irq_hold", {31'd0, irq}, {31'd0, IRQ_ON});
                @(negedge clk);
                check_eq("irq_drop", {31'd0, irq}, 32'd0);
                repeat (4) @(negedge clk);
                bus_write(OFF_BAUD, 32'd7);
                bus_write(OFF_TXDATA, {24'd0, by});
            end
        join
        expect_frame(by, 7, 1, "mid_new");

        // Asynchronous reset in the middle of a data bit.
        bus_write(OFF_TXDATA, 32'h0000_0055);
        bus_write(OFF_TXDATA, 32'h0000_0033);
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_eq("arst_txd", {31'd0, uart_txd}, 32'd1);
        bus_read(OFF_STATUS, rd); check_eq("arst_status", rd, 32'h0000_0004);
        @(negedge clk);
        reset = 1'b1;
        bus_read(OFF_BAUD, rd); check_eq("arst_baud", rd, 32'd433);
        bus_write(OFF_CTRL, 32'd1);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            if (uart_txd !== 1'b1) lows++;
            @(negedge clk);
        end
        check_eq("arst_no_frame", 32'(lows), 32'd0);

        // Randomized rounds against the byte-queue model.
        for (int r = 0; r < 4; r++) begin
            bus_write(OFF_CTRL, 32'd0);
            div = $urandom_range(0, 3);
            bus_write(OFF_BAUD, 32'(div));
            n   = $urandom_range(1, 6);
            ovf = 1'b0;
            q.delete();
            for (int i = 0; i < n; i++) begin
                bx = 8'($urandom);
                if (q.size() < DEPTH) q.push_back(bx);
                else                  ovf = 1'b1;
                bus_write(OFF_TXDATA, {24'd0, bx});
            end
            bus_read(OFF_STATUS, rd);
            check_eq("rnd_status", rd, status_exp(0, (q.size() == DEPTH) ? 1 : 0, 0,
                                                  ovf ? 1 : 0, q.size()));
            if (ovf) begin
                bus_write(OFF_STATUS, 32'h0000_0008);
                bus_read(OFF_STATUS, rd);
                check_eq("rnd_w1c", rd, status_exp(0, (q.size() == DEPTH) ? 1 : 0, 0, 0,
                                                   q.size()));
            end
            bus_write(OFF_CTRL, 32'd1);
            while (q.size() > 0) expect_frame(q.pop_front(), div, 1, "rnd");
            bus_read(OFF_STATUS, rd); check_eq("rnd_idle_status", rd, 32'h0000_0004);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
